sync_fifo_level_buffer: RTL and testbench
=========================================

// Module: sync_fifo_level_buffer
// PURPOSE
//  Parametrised synchronous FIFO. Circular queue with read and write pointers plus an occupancy counter.
//  Generalises the team's sync FIFO: any DATA_WIDTH, any DEPTH>=2 (not only powers of two).
//  Adds a fill-level output, almost-full/almost-empty thresholds, a synchronous flush and a selectable read mode.
//  Sits between producer and consumer blocks that share one clock domain.
// PARAMETERS
//  DATA_WIDTH  32  word width in bits
//  DEPTH       32  words stored; >=2; any integer
//  FWFT        1   1: first-word-fall-through head; 0: registered read, 1-cycle latency
//  AF_LEVEL    28  almost_full_o asserted when count >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL    4   almost_empty_o asserted when count <= AE_LEVEL (0..DEPTH-1)
// PORTS
//  clk_i           in   1                       clock, rising edge
//  rst_i           in   1                       reset: synchronous, active-high
//  flush_i         in   1                       synchronous clear of FIFO state
//  write_i         in   1                       write request
//  wr_data_i       in   DATA_WIDTH              write data
//  read_i          in   1                       read request (pop)
//  rd_data_o       out  DATA_WIDTH              read data
//  rd_valid_o      out  1                       rd_data_o holds a valid word
//  full_o          out  1                       count == DEPTH
//  empty_o         out  1                       count == 0
//  almost_full_o   out  1                       count >= AF_LEVEL
//  almost_empty_o  out  1                       count <= AE_LEVEL
//  count_o         out  $clog2(DEPTH+1)         words currently stored
//  overflow_o      out  1                       sticky write-while-full error
//  underflow_o     out  1                       sticky read-while-empty error
// BEHAVIOUR
//  Reset (rst_i=1 at edge): ptrs=0, count_o=0, empty_o=1, almost_empty_o=1, full_o=0, almost_full_o=0,
//   rd_valid_o=0, rd_data_o='0, overflow_o=0, underflow_o=0. Memory is not cleared.
//  rst_i takes priority over flush_i, which takes priority over read/write.
//  flush_i: same state as reset except memory; an in-flight standard-mode read is dropped (rd_valid_o=0).
//  read_en  = read_i & !empty_o.
//  write_en = write_i & (!full_o | read_en). A write into a full FIFO succeeds when a pop happens in the same cycle.
//  Count update: +1 on write_en only, -1 on read_en only, unchanged on both or neither.
//  Empty FIFO with both requests: read ignored, write accepted, count becomes 1.
//  Pointers wrap from DEPTH-1 to 0. Power-of-two DEPTH uses a natural rollover.
//  All status outputs are registered and derived from the next count; they are valid the cycle after an edge.
//  FWFT=1: rd_data_o = mem[rd_ptr] combinational. rd_valid_o = !empty_o. read_i pops the shown word.
//  FWFT=0: on read_en, rd_data_o <= mem[rd_ptr] at the edge, and rd_valid_o=1 for exactly that next cycle.
//   rd_data_o holds its value otherwise.
//  Write-then-read of the same address: data written at edge N is readable from the cycle after N.
//   There is no same-cycle bypass.
// CONFIGURATION
//  Macro SYNC_FIFO_ERR_FLAGS_EN.
//  Defined: overflow_o sets when write_i & !write_en. underflow_o sets when read_i & empty_o.
//   Both flags are sticky and cleared only by rst_i or flush_i.
//  Undefined: both ports remain present and are tied to 0; no error logic is synthesised.
// STRUCTURE
//  Package sync_fifo_pkg: read-mode enum {STANDARD, FWFT}; count-width function cnt_width(depth)=$clog2(depth+1).
//  Sub-module sync_fifo_ram: DEPTH x DATA_WIDTH, one write port, one read port.
//   Read port is combinational or registered, selected by FWFT.
//   Top level holds pointers, counter, flags and error logic.
// TESTING
//  1. Reset, then DEPTH=5, FWFT=1: write 5 words 0xA0..0xA4.
//     -> full_o=1, count_o=5; pops return A0..A4 in order; empty_o=1 after the 5th pop.
//  2. FIFO full, write_i & read_i for 3 cycles.
//     -> count_o stays 5, full_o stays 1, order preserved across pointer wrap.
//  3. FWFT=0: write 0x55, then read_i.
//     -> rd_data_o=0x55 with rd_valid_o=1 exactly one cycle after the read edge.
//  4. AF_LEVEL=4, AE_LEVEL=1: fill 0..5 words.
//     -> almost_empty_o at counts 0..1, almost_full_o at counts 4..5.
//  5. Flush_i with count 3 and read_i asserted in the same cycle.
//     -> next cycle count_o=0, empty_o=1, rd_valid_o=0; rst_i with flush_i -> reset values.
//  6. SYNC_FIFO_ERR_FLAGS_EN: write while full without a read -> overflow_o=1, count unchanged;
//     read while empty -> underflow_o=1; both flags remain set until flush_i.

Source files
------------

// File: rtl/sync_fifo_level_buffer_pkg.sv
// Shared types and helpers for the level-reporting sync FIFO.
// Read-mode enum and counter-width helper.
package sync_fifo_pkg;

  typedef enum logic {
    STANDARD = 1'b0,
    FWFT     = 1'b1
  } rd_mode_e;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_level_buffer_if.sv
// Producer/consumer bundle for the sync FIFO.
// master drives requests; slave is the FIFO.
interface sync_fifo_level_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32
);
  import sync_fifo_pkg::*;

  localparam int CW = cnt_width(DEPTH);

  logic                  flush_i;
  logic                  write_i;
  logic [DATA_WIDTH-1:0] wr_data_i;
  logic                  read_i;
  logic [DATA_WIDTH-1:0] rd_data_o;
  logic                  rd_valid_o;
  logic                  full_o;
  logic                  empty_o;
  logic                  almost_full_o;
  logic                  almost_empty_o;
  logic [CW-1:0]         count_o;
  logic                  overflow_o;
  logic                  underflow_o;

  modport master (
    output flush_i, write_i, wr_data_i, read_i,
    input  rd_data_o, rd_valid_o, full_o, empty_o,
    input  almost_full_o, almost_empty_o, count_o,
    input  overflow_o, underflow_o
  );

  modport slave (
    input  flush_i, write_i, wr_data_i, read_i,
    output rd_data_o, rd_valid_o, full_o, empty_o,
    output almost_full_o, almost_empty_o, count_o,
    output overflow_o, underflow_o
  );

endinterface

// File: rtl/sync_fifo_level_buffer_ram.sv
// DEPTH x DATA_WIDTH storage, one write and one read port.
// Read port is combinational or registered (REG_RD).
module sync_fifo_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int AW         = 5,
  parameter bit REG_RD     = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  clr_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Storage write; contents survive reset and flush.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  if (REG_RD) begin : g_reg
    logic [DATA_WIDTH-1:0] rdata_q;

    // Registered read; holds until the next pop, clears with FIFO state.
    always_ff @(posedge clk_i) begin
      if (clr_i)     rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
  end else begin : g_comb
    logic unused_rd;
    assign unused_rd = clr_i ^ re_i;
    assign rdata_o   = mem_q[raddr_i];
  end

endmodule

// File: rtl/sync_fifo_level_buffer.sv
// Synchronous FIFO with fill level, thresholds, flush and read mode.
// Optional sticky error flags: SYNC_FIFO_ERR_FLAGS_EN.
module sync_fifo_level_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int FWFT       = 1,
  parameter int AF_LEVEL   = 28,
  parameter int AE_LEVEL   = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  sync_fifo_level_buffer_if.slave bus
);
  import sync_fifo_pkg::*;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = cnt_width(DEPTH);
  localparam rd_mode_e MODE =
    (FWFT != 0) ? sync_fifo_pkg::FWFT : STANDARD;

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q;
  logic          afull_q, aempty_q;
  logic          rd_en, wr_en, clr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  function automatic logic [AW-1:0] ptr_inc(
    input logic [AW-1:0] p
  );
    if (p == AW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign clr   = rst_i | bus.flush_i;
  assign rd_en = bus.read_i & ~empty_q;
  assign wr_en = bus.write_i & (~full_q | rd_en);

  // Next pointers and occupancy.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_en) wptr_d = ptr_inc(wptr_q);
    if (rd_en) rptr_d = ptr_inc(rptr_q);
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer, counter and status registers.
  always_ff @(posedge clk_i) begin
    if (clr) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CW'(DEPTH));
      empty_q  <= (count_d == '0);
      afull_q  <= (count_d >= CW'(AF_LEVEL));
      aempty_q <= (count_d <= CW'(AE_LEVEL));
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW),
    .REG_RD     (MODE == STANDARD)
  ) u_ram (
    .clk_i   (clk_i),
    .clr_i   (clr),
    .we_i    (wr_en & ~clr),
    .waddr_i (wptr_q),
    .wdata_i (bus.wr_data_i),
    .re_i    (rd_en & ~clr),
    .raddr_i (rptr_q),
    .rdata_o (ram_rdata)
  );

  if (MODE == STANDARD) begin : g_std
    logic rvalid_q;

    // One-cycle valid strobe following each pop.
    always_ff @(posedge clk_i) begin
      if (clr) rvalid_q <= 1'b0;
      else     rvalid_q <= rd_en;
    end

    assign bus.rd_valid_o = rvalid_q;
    assign bus.rd_data_o  = ram_rdata;
  end else begin : g_fwft
    assign bus.rd_valid_o = ~empty_q;
    assign bus.rd_data_o  = empty_q ? '0 : ram_rdata;
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic ovf_q, unf_q;

  // Sticky error flags; only reset or flush clear them.
  always_ff @(posedge clk_i) begin
    if (clr) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (bus.write_i & ~wr_en)  ovf_q <= 1'b1;
      if (bus.read_i  & empty_q) unf_q <= 1'b1;
    end
  end

  assign bus.overflow_o  = ovf_q;
  assign bus.underflow_o = unf_q;
`else
  assign bus.overflow_o  = 1'b0;
  assign bus.underflow_o = 1'b0;
`endif

  assign bus.count_o        = count_q;
  assign bus.full_o         = full_q;
  assign bus.empty_o        = empty_q;
  assign bus.almost_full_o  = afull_q;
  assign bus.almost_empty_o = aempty_q;

endmodule

// File: tb/tb_sync_fifo_level_buffer.sv
// Directed bench: FWFT and standard-mode instances,
// DEPTH=5, AF_LEVEL=4, AE_LEVEL=1.
module tb_sync_fifo_level_buffer;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  localparam logic EF = 1'b1;
`else
  localparam logic EF = 1'b0;
`endif

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  sync_fifo_level_buffer_if #(.DATA_WIDTH(8), .DEPTH(5)) ia ();
  sync_fifo_level_buffer_if #(.DATA_WIDTH(8), .DEPTH(5)) ib ();

  sync_fifo_level_buffer #(
    .DATA_WIDTH (8),
    .DEPTH      (5),
    .FWFT       (1),
    .AF_LEVEL   (4),
    .AE_LEVEL   (1)
  ) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ia)
  );

  sync_fifo_level_buffer #(
    .DATA_WIDTH (8),
    .DEPTH      (5),
    .FWFT       (0),
    .AF_LEVEL   (4),
    .AE_LEVEL   (1)
  ) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    ia.flush_i = 0; ia.write_i = 0; ia.read_i = 0; ia.wr_data_i = '0;
    ib.flush_i = 0; ib.write_i = 0; ib.read_i = 0; ib.wr_data_i = '0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_count", ia.count_o, 0);
    chk("rst_empty", ia.empty_o, 1);
    chk("rst_aempty", ia.almost_empty_o, 1);
    chk("rst_full", ia.full_o, 0);
    chk("rst_afull", ia.almost_full_o, 0);
    chk("rst_valid", ia.rd_valid_o, 0);
    chk("rst_data", ia.rd_data_o, 0);
    chk("rst_ovf", ia.overflow_o, 0);
    chk("rst_unf", ia.underflow_o, 0);
    chk("rst_b_valid", ib.rd_valid_o, 0);
    chk("rst_b_data", ib.rd_data_o, 0);

    // Fill 5 words, watch levels and thresholds.
    for (int i = 0; i < 5; i++) begin
      ia.write_i = 1;
      ia.wr_data_i = 8'hA0 + 8'(i);
      tick();
      chk("fill_count", ia.count_o, i + 1);
      chk("fill_aempty", ia.almost_empty_o, (i + 1 <= 1));
      chk("fill_afull", ia.almost_full_o, (i + 1 >= 4));
      chk("fill_head", ia.rd_data_o, 8'hA0);
      chk("fill_valid", ia.rd_valid_o, 1);
    end
    ia.write_i = 0;
    chk("full_flag", ia.full_o, 1);
    chk("full_empty", ia.empty_o, 0);

    // Drain in order.
    for (int i = 0; i < 5; i++) begin
      chk("pop_data", ia.rd_data_o, 8'hA0 + i);
      ia.read_i = 1;
      tick();
      chk("pop_count", ia.count_o, 4 - i);
      chk("pop_aempty", ia.almost_empty_o, (4 - i <= 1));
      chk("pop_afull", ia.almost_full_o, (4 - i >= 4));
    end
    ia.read_i = 0;
    chk("drain_empty", ia.empty_o, 1);
    chk("drain_valid", ia.rd_valid_o, 0);
    chk("drain_full", ia.full_o, 0);

    // Refill, then simultaneous push/pop while full.
    for (int i = 0; i < 5; i++) begin
      ia.write_i = 1;
      ia.wr_data_i = 8'hB0 + 8'(i);
      tick();
    end
    chk("refill_full", ia.full_o, 1);
    for (int i = 0; i < 3; i++) begin
      chk("rw_head", ia.rd_data_o, 8'hB0 + i);
      ia.write_i = 1;
      ia.read_i = 1;
      ia.wr_data_i = 8'hC0 + 8'(i);
      tick();
      chk("rw_count", ia.count_o, 5);
      chk("rw_full", ia.full_o, 1);
    end
    ia.read_i = 0;

    // Write while full without a pop.
    ia.write_i = 1;
    ia.wr_data_i = 8'hEE;
    tick();
    ia.write_i = 0;
    chk("ovf_count", ia.count_o, 5);
    chk("ovf_flag", ia.overflow_o, EF);
    chk("ovf_head", ia.rd_data_o, 8'hB3);

    // Drain across the wrap; dropped word must not appear.
    chk("wrap_d0", ia.rd_data_o, 8'hB3);
    ia.read_i = 1; tick();
    chk("wrap_d1", ia.rd_data_o, 8'hB4);
    tick();
    chk("wrap_d2", ia.rd_data_o, 8'hC0);
    tick();
    chk("wrap_d3", ia.rd_data_o, 8'hC1);
    tick();
    chk("wrap_d4", ia.rd_data_o, 8'hC2);
    tick();
    chk("wrap_empty", ia.empty_o, 1);
    chk("unf_clear", ia.underflow_o, 0);

    // Read while empty.
    tick();
    ia.read_i = 0;
    chk("unf_flag", ia.underflow_o, EF);
    chk("unf_count", ia.count_o, 0);
    chk("unf_ovf_hold", ia.overflow_o, EF);

    // Empty with both requests: write wins, read ignored.
    ia.write_i = 1; ia.read_i = 1; ia.wr_data_i = 8'hD0;
    tick();
    ia.read_i = 0;
    chk("both_count", ia.count_o, 1);
    chk("both_head", ia.rd_data_o, 8'hD0);
    ia.wr_data_i = 8'hD1; tick();
    ia.wr_data_i = 8'hD2; tick();
    ia.write_i = 0;
    chk("pre_flush_cnt", ia.count_o, 3);
    chk("pre_flush_ovf", ia.overflow_o, EF);

    // Flush with a concurrent pop.
    ia.flush_i = 1; ia.read_i = 1;
    tick();
    ia.flush_i = 0; ia.read_i = 0;
    chk("flush_count", ia.count_o, 0);
    chk("flush_empty", ia.empty_o, 1);
    chk("flush_valid", ia.rd_valid_o, 0);
    chk("flush_ovf", ia.overflow_o, 0);
    chk("flush_unf", ia.underflow_o, 0);
    chk("flush_aempty", ia.almost_empty_o, 1);

    // Reset beats flush and write.
    ia.write_i = 1; ia.wr_data_i = 8'h11;
    tick();
    chk("pre_rst_count", ia.count_o, 1);
    rst = 1; ia.flush_i = 1; ia.wr_data_i = 8'h22;
    tick();
    rst = 0; ia.flush_i = 0; ia.write_i = 0;
    chk("rstfl_count", ia.count_o, 0);
    chk("rstfl_empty", ia.empty_o, 1);
    chk("rstfl_data", ia.rd_data_o, 0);

    // Standard mode: one-cycle latency, valid strobe.
    ib.write_i = 1; ib.wr_data_i = 8'h55;
    tick();
    ib.write_i = 0;
    chk("std_wr_valid", ib.rd_valid_o, 0);
    chk("std_wr_count", ib.count_o, 1);
    ib.read_i = 1;
    tick();
    ib.read_i = 0;
    chk("std_rd_valid", ib.rd_valid_o, 1);
    chk("std_rd_data", ib.rd_data_o, 8'h55);
    tick();
    chk("std_strobe", ib.rd_valid_o, 0);
    chk("std_hold", ib.rd_data_o, 8'h55);

    ib.write_i = 1; ib.wr_data_i = 8'h66; tick();
    ib.wr_data_i = 8'h77; tick();
    ib.write_i = 0;
    ib.read_i = 1;
    tick();
    chk("std_rd2_data", ib.rd_data_o, 8'h66);
    chk("std_rd2_valid", ib.rd_valid_o, 1);
    ib.flush_i = 1;
    tick();
    ib.flush_i = 0; ib.read_i = 0;
    chk("std_fl_valid", ib.rd_valid_o, 0);
    chk("std_fl_data", ib.rd_data_o, 0);
    chk("std_fl_count", ib.count_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
